// File: rtl/modmul_arbiter.sv
// modmul_arbiter: round-robin sequencer that shares one shift-add modular
// multiplier between NREQ ECC sub-units. The winner's operands are latched
// and held for the whole multiplication; the product is returned with a
// one-cycle one-hot done strobe.
//
// Optional build macro MODMUL_ARB_RANGE_CHECK_EN adds an o_err output and an
// operand range check (a >= n or b >= n completes at once with o_err=1 and a
// zero result, without starting the multiplier).
//
// Handshake: a requester holds its i_req bit and operands stable from the
// cycle it raises i_req until the cycle its o_done bit pulses, then drops
// i_req; the multiplier sees o_mul_start for exactly one cycle and answers
// with a one-cycle i_mul_finished pulse, which is honoured only in WAIT.
module modmul_arbiter #(
    parameter int WIDTH = 256,
    parameter int NREQ  = 2,
    parameter int PTRW  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_a,
    input  logic [NREQ*WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0]      i_n,
    output logic [NREQ-1:0]       o_grant,
    output logic [NREQ-1:0]       o_done,
    output logic [WIDTH-1:0]      o_result,
    output logic                  o_busy,
    output logic                  o_mul_start,
    output logic [WIDTH-1:0]      o_mul_a,
    output logic [WIDTH-1:0]      o_mul_b,
    output logic [WIDTH-1:0]      o_mul_n,
    input  logic [WIDTH-1:0]      i_mul_result,
    input  logic                  i_mul_finished
`ifdef MODMUL_ARB_RANGE_CHECK_EN
    ,
    output logic                  o_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PTRW-1:0]   ptr;
    logic [PTRW-1:0]   grant_idx;
    logic [PTRW-1:0]   win_idx;
    logic              win_found;
    logic [NREQ-1:0]   win_onehot;
    logic [WIDTH-1:0]  win_a;
    logic [WIDTH-1:0]  win_b;
    logic [PTRW-1:0]   ptr_nxt;

`ifdef MODMUL_ARB_RANGE_CHECK_EN
    logic              range_bad;
    assign range_bad = (win_a >= i_n) || (win_b >= i_n);
`endif

    assign win_a      = i_a[win_idx*WIDTH +: WIDTH];
    assign win_b      = i_b[win_idx*WIDTH +: WIDTH];
    assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    assign ptr_nxt    = (grant_idx == PTRW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

    // Round-robin scan: first requesting index at or above ptr, wrapping at NREQ.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!win_found && i_req[j]) begin
                win_found = 1'b1;
                win_idx   = PTRW'(j);
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (win_found) begin
`ifdef MODMUL_ARB_RANGE_CHECK_EN
                    state_nxt = range_bad ? RESP : ISSUE;
`else
                    state_nxt = ISSUE;
`endif
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (i_mul_finished) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, operand latches and round-robin pointer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr         <= '0;
            grant_idx   <= '0;
            o_grant     <= '0;
            o_done      <= '0;
            o_result    <= '0;
            o_busy      <= 1'b0;
            o_mul_start <= 1'b0;
            o_mul_a     <= '0;
            o_mul_b     <= '0;
            o_mul_n     <= '0;
`ifdef MODMUL_ARB_RANGE_CHECK_EN
            o_err       <= 1'b0;
`endif
        end else begin
            o_mul_start <= 1'b0;
            o_done      <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        o_mul_a   <= win_a;
                        o_mul_b   <= win_b;
                        o_mul_n   <= i_n;
                        o_grant   <= win_onehot;
                        grant_idx <= win_idx;
                        o_busy    <= 1'b1;
`ifdef MODMUL_ARB_RANGE_CHECK_EN
                        if (range_bad) begin
                            o_done   <= win_onehot;
                            o_result <= '0;
                            o_err    <= 1'b1;
                        end else begin
                            o_mul_start <= 1'b1;
                        end
`else
                        o_mul_start <= 1'b1;
`endif
                    end
                end
                WAIT: begin
                    // Operands stay put here; the multiplier reads them serially.
                    if (i_mul_finished) begin
                        o_result <= i_mul_result;
                        o_done   <= o_grant;
                    end
                end
                RESP: begin
                    ptr     <= ptr_nxt;
                    o_grant <= '0;
                    o_busy  <= 1'b0;
`ifdef MODMUL_ARB_RANGE_CHECK_EN
                    o_err   <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modmul_arbiter.sv
// Bench for modmul_arbiter: directed vectors with hand-computed products,
// a behavioural multiplier stub, and a done/result scoreboard.
module tb_modmul_arbiter;

    localparam int WIDTH = 256;
    localparam int NREQ  = 2;
    localparam int PTRW  = 2;
    localparam int LAT   = 6;
    localparam int EXPW  = 1 + NREQ + WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_bus;
    logic [NREQ*WIDTH-1:0] b_bus;
    logic [WIDTH-1:0]      n;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  busy;
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [WIDTH-1:0]      mul_n;
    logic [WIDTH-1:0]      mul_result;
    logic                  mul_finished;
    logic                  stub_fin;
    logic [WIDTH-1:0]      stub_res;
    logic                  glitch_fin;
    logic                  err;

    int vec_cnt   = 0;
    int err_cnt   = 0;
    int start_cnt = 0;

    logic [EXPW-1:0] exp_q[$];

    assign mul_finished = stub_fin | glitch_fin;
    assign mul_result   = glitch_fin ? WIDTH'(999) : stub_res;

    modmul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .PTRW(PTRW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req          (req),
        .i_a            (a_bus),
        .i_b            (b_bus),
        .i_n            (n),
        .o_grant        (grant),
        .o_done         (done),
        .o_result       (result),
        .o_busy         (busy),
        .o_mul_start    (mul_start),
        .o_mul_a        (mul_a),
        .o_mul_b        (mul_b),
        .o_mul_n        (mul_n),
        .i_mul_result   (mul_result),
        .i_mul_finished (mul_finished)
`ifdef MODMUL_ARB_RANGE_CHECK_EN
        ,
        .o_err          (err)
`endif
    );

`ifndef MODMUL_ARB_RANGE_CHECK_EN
    assign err = 1'b0;
`endif

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [EXPW-1:0] act, input logic [EXPW-1:0] expv);
        vec_cnt++;
        if (act !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_grant"},     grant,     0);
        check({tag, "_done"},      done,      0);
        check({tag, "_result"},    result,    0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_mul_a"},     mul_a,     0);
        check({tag, "_mul_b"},     mul_b,     0);
        check({tag, "_mul_n"},     mul_n,     0);
        check({tag, "_err"},       err,       0);
    endtask

    // multiplier stub: fixed latency, aborts on reset, checks operand hold
    initial begin
        logic [WIDTH-1:0] ma, mb, mn;
        logic aborted, hold_ok;
        stub_fin = 1'b0;
        stub_res = '0;
        forever begin
            @(negedge clk);
            if (mul_start && !rst) begin
                ma = mul_a; mb = mul_b; mn = mul_n;
                aborted = 1'b0;
                hold_ok = 1'b1;
                for (int c = 0; c < LAT; c++) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                    if (mul_a !== ma || mul_b !== mb || mul_n !== mn) hold_ok = 1'b0;
                end
                if (!aborted) begin
                    check("operand_hold", hold_ok, 1);
                    stub_res = (ma * mb) % mn;
                    stub_fin = 1'b1;
                    @(negedge clk);
                    stub_fin = 1'b0;
                end
            end
        end
    end

    // monitor / scoreboard: every done strobe pops one expectation
    always @(negedge clk) begin
        if (mul_start) start_cnt++;
        if (done != '0) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_done: got done=%b result=%0h required no done", done, result);
            end else begin
                check("done_result", {err, done, result}, exp_q.pop_front());
            end
        end
    end

    // driver: one requester alone; optional glitch pulses in IDLE and ISSUE
    task automatic run_op(input int k, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] expres, input logic experr,
                          input int exp_starts, input bit glitch, output int cycles);
        logic [NREQ-1:0] oh;
        int s0;
        bit gok, seen;
        oh = NREQ'(1) << k;
        a_bus[k*WIDTH +: WIDTH] = av;
        b_bus[k*WIDTH +: WIDTH] = bv;
        if (glitch) begin
            glitch_fin = 1'b1;
            @(negedge clk);
            glitch_fin = 1'b0;
        end
        exp_q.push_back({experr, oh, expres});
        s0 = start_cnt;
        gok = 1'b1;
        seen = 1'b0;
        cycles = 0;
        req[k] = 1'b1;
        if (glitch) glitch_fin = 1'b1;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (glitch && c == 1) glitch_fin = 1'b0;
            if (grant !== oh) gok = 1'b0;
            if (done != '0) begin
                seen = 1'b1;
                cycles = c;
            end
        end
        req[k] = 1'b0;
        glitch_fin = 1'b0;
        check("done_seen", seen, 1);
        check("grant_hold", gok, 1);
        check("start_count", start_cnt - s0, exp_starts);
        repeat (2) @(negedge clk);
    endtask

    // driver: both requesters held, expecting strict alternation from r0
    task automatic run_pair(input int nops);
        int got;
        a_bus[0*WIDTH +: WIDTH] = WIDTH'(2);
        b_bus[0*WIDTH +: WIDTH] = WIDTH'(3);
        a_bus[1*WIDTH +: WIDTH] = WIDTH'(96);
        b_bus[1*WIDTH +: WIDTH] = WIDTH'(96);
        for (int i = 0; i < nops; i++) begin
            if (i % 2 == 0) exp_q.push_back({1'b0, 2'b01, WIDTH'(6)});
            else            exp_q.push_back({1'b0, 2'b10, WIDTH'(1)});
        end
        got = 0;
        req = 2'b11;
        for (int c = 0; c < 1000 && got < nops; c++) begin
            @(negedge clk);
            if (done != '0) got++;
        end
        req = '0;
        check("pair_done_count", got, nops);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cyc;
        bit seen;
        rst = 1'b1;
        req = '0;
        a_bus = '0;
        b_bus = '0;
        n = WIDTH'(97);
        glitch_fin = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);

        // requester 0: 5*7 mod 97 = 35
        run_op(0, 5, 7, 35, 1'b0, 1, 1'b0, cyc);
        // requester 1 alone: 50*3 mod 97 = 53, ptr returns to 0
        run_op(1, 50, 3, 53, 1'b0, 1, 1'b0, cyc);
        // both held: r0 first (ptr 0), alternating 6 / 1
        run_pair(4);
        // finished pulses in IDLE and ISSUE must be ignored
        run_op(0, 5, 7, 35, 1'b0, 1, 1'b1, cyc);

        // reset in the middle of WAIT
        a_bus[0 +: WIDTH] = WIDTH'(5);
        b_bus[0 +: WIDTH] = WIDTH'(7);
        req[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mul_start) seen = 1'b1;
        end
        check("wait_start_seen", seen, 1);
        repeat (2) @(negedge clk);
        check("mid_wait_busy", busy, 1);
        #2 rst = 1'b1;
        #1 check_reset("mid_wait");
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("post_reset_idle_busy", busy, 0);
        run_op(0, 5, 7, 35, 1'b0, 1, 1'b0, cyc);

        // fresh reset, both requests raised straight away
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_pair(2);

`ifdef MODMUL_ARB_RANGE_CHECK_EN
        // a=100 >= n: immediate error completion, multiplier untouched
        run_op(0, 100, 2, 0, 1'b1, 0, 1'b0, cyc);
        vec_cnt++;
        if (cyc > 2) begin
            err_cnt++;
            $display("FAIL range_latency: got %0d cycles required <= 2", cyc);
        end
        run_op(1, 96, 96, 1, 1'b0, 1, 1'b0, cyc);
`endif

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/modmul_arbiter.md
Name: modmul_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one ModuloProduct shift-add modular multiplier between NREQ ECC sub-units (point-add, point-double, inversion).
- Latches the winning requester's operands and holds them stable for the whole multiplication.
- Pulses the multiplier start, waits for its finished pulse, then returns the registered product to the owning requester with a one-cycle done strobe.
- Sits between the ECC point-arithmetic controllers and the single multiplier instance.

Parameters:
- WIDTH, 256: operand/modulus width; must equal `WIDTH used by the multiplier.
- NREQ, 2: number of requesters, 2..4.
- PTRW, 2: round-robin pointer width; must satisfy 2^PTRW >= NREQ.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req  in  NREQ  per-requester request level.
- i_a  in  NREQ*WIDTH  packed multiplicand; slice k belongs to requester k.
- i_b  in  NREQ*WIDTH  packed multiplier operand, same packing as i_a.
- i_n  in  WIDTH  shared modulus (curve prime), static during operation.
- o_grant  out  NREQ  one-hot owner of the multiplier; 0 when idle.
- o_done  out  NREQ  one-hot, one-cycle completion strobe.
- o_result  out  WIDTH  product (a*b) mod n; valid while o_done != 0.
- o_busy  out  1  high in any state other than IDLE.
- o_mul_start  out  1  one-cycle start pulse to the multiplier.
- o_mul_a  out  WIDTH  latched a to the multiplier.
- o_mul_b  out  WIDTH  latched b to the multiplier.
- o_mul_n  out  WIDTH  latched n to the multiplier.
- i_mul_result  in  WIDTH  multiplier result.
- i_mul_finished  in  1  multiplier one-cycle finished pulse.

Behaviour:
- All outputs are registered.
- Reset (async, any state, including mid-multiplication):
  - state=IDLE, ptr=0, o_grant=0, o_done=0, o_result=0, o_busy=0, o_mul_start=0, o_mul_a/b/n=0.
  - The multiplier shares i_rst, so no pending operation survives reset.
- State machine IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If i_req != 0, pick the first set bit scanning from ptr upward, wrapping at NREQ.
  - Latch that requester's a and b, plus i_n, into o_mul_a/b/n.
  - Set o_grant one-hot and o_busy=1, then go to ISSUE.
  - If i_req == 0, stay in IDLE.
- ISSUE: o_mul_start=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - o_mul_a/b/n are held constant; the multiplier reads a bit-serially, so the operands must not move.
  - Remain in WAIT until i_mul_finished=1.
  - On that cycle capture i_mul_result into o_result and go to RESP.
  - No timeout; WAIT never depends on the multiplier's exact latency.
- RESP:
  - o_done[g]=1 for one cycle, where g is the granted index; o_result is valid.
  - Set ptr = (g+1) mod NREQ, clear o_grant, go to IDLE.
  - o_busy falls on the next cycle.
- Requester contract:
  - Hold i_req high and operands stable until own o_done, then drop i_req in the following cycle.
  - Dropping i_req after grant does not abort the operation; it completes and o_done still pulses.
  - A request still high in the IDLE cycle after RESP is re-arbitrated.
- Throughput: one operation per (multiplier latency + 3) cycles.
- Minimum idle gap: one IDLE cycle between operations.
- Fairness: a continuously asserted request is served within NREQ-1 other operations.
- i_mul_finished outside WAIT is ignored.
- Operands must satisfy b < n (the multiplier's doubling step reduces only once).

Optional Feature:
- Macro MODMUL_ARB_RANGE_CHECK_EN.
- Defined:
  - Adds output o_err (1 bit, reset 0).
  - In IDLE, if the winner's a >= n or b >= n, skip ISSUE/WAIT and go straight to RESP.
  - In that RESP: o_done[g]=1, o_err=1, o_result=0; the multiplier is never started.
  - o_err is 0 on all valid completions.
- Undefined: no o_err port and no comparison logic; out-of-range operands give undefined results.

Test Plan:
1. Reset mid-WAIT with requester 0 active -> all outputs 0 next cycle; no o_done pulse; a new request afterwards completes normally.
2. n=97, requester 0: a=5, b=7 -> o_mul_start exactly once; o_done=01 once; o_result=35; o_grant=01 throughout.
3. n=97, requester 1 alone: a=50, b=3 -> o_result=53; o_done=10; ptr then points to 0.
4. n=97, both requesters held from reset: r0 a=2 b=3, r1 a=96 b=96 -> r0 served first (result 6), then r1 (result 1); grants alternate over 4 repeated operations.
5. i_mul_finished pulsed while in IDLE and ISSUE -> ignored; only the WAIT-state pulse completes the operation.
6. Macro defined, n=97, a=100, b=2 -> o_done pulses with o_err=1 and o_result=0 within 2 cycles of grant, o_mul_start never asserted. Macro undefined -> o_err port absent.
